// File: rtl/isqrt_iter_fsm.sv
// Iterative integer square root, y = floor(sqrt(x)).
// Restoring digit-by-digit method, one result bit per clock.
module isqrt_iter_fsm #(
   parameter int X_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   x_vld,
   input  logic [X_WIDTH-1:0]     x,
   output logic                   y_vld,
   output logic [X_WIDTH/2-1:0]   y,
   output logic                   busy
);

   localparam int Y_WIDTH = X_WIDTH / 2;
   localparam int CNT_W   = (Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1;

   typedef enum logic {
      IDLE,
      CALC
   } state_t;

   state_t               r_state;
   logic [X_WIDTH-1:0]   r_x_sr;
   logic [Y_WIDTH-1:0]   r_rem;
   logic [Y_WIDTH-1:0]   r_root;
   logic [CNT_W-1:0]     r_cnt;
   logic [Y_WIDTH-1:0]   r_y;
   logic                 r_y_vld;

   logic [Y_WIDTH+1:0]   w_rem_t;
   logic [Y_WIDTH+1:0]   w_trial;
   logic                 w_ge;
   logic [Y_WIDTH-1:0]   w_root_nxt;
   logic [Y_WIDTH-1:0]   w_rem_nxt;
   logic                 w_last;

   // Remainder never exceeds 2*root before the last step, so Y_WIDTH bits hold it.
   assign w_rem_t    = {r_rem, r_x_sr[X_WIDTH-1:X_WIDTH-2]};
   assign w_trial    = {r_root, 2'b01};
   assign w_ge       = (w_rem_t >= w_trial);
   assign w_root_nxt = {r_root[Y_WIDTH-2:0], w_ge};
   assign w_rem_nxt  = w_ge ? Y_WIDTH'(w_rem_t - w_trial)
                          : Y_WIDTH'(w_rem_t);
   assign w_last     = (r_cnt == CNT_W'(Y_WIDTH - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_x_sr  <= '0;
         r_rem   <= '0;
         r_root  <= '0;
         r_cnt   <= '0;
         r_y     <= '0;
         r_y_vld <= 1'b0;
      end else begin
         r_y_vld <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (x_vld) begin
                  r_x_sr  <= x;
                  r_rem   <= '0;
                  r_root  <= '0;
                  r_cnt   <= '0;
                  r_state <= CALC;
               end
            end
            CALC: begin
               r_x_sr <= {r_x_sr[X_WIDTH-3:0], 2'b00};
               r_rem  <= w_rem_nxt;
               r_root <= w_root_nxt;
               r_cnt  <= r_cnt + 1'b1;
               if (w_last) begin
                  r_y     <= w_root_nxt;
                  r_y_vld <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign y_vld = r_y_vld;
   assign y     = r_y;
   assign busy  = (r_state == CALC);

endmodule

// File: tb/tb_isqrt_iter_fsm.sv
// Self-checking bench for isqrt_iter_fsm.
// Directed table, multi-cycle sequences and bounded random sweep.
module tb_isqrt_iter_fsm;

   localparam int XW = 32;
   localparam int YW = 16;

   logic          clk   = 1'b0;
   logic          rst   = 1'b0;
   logic          x_vld = 1'b0;
   logic [XW-1:0] x     = '0;
   logic          y_vld;
   logic [YW-1:0] y;
   logic          busy;

   int n_chk   = 0;
   int n_err   = 0;
   int n_pulse = 0;
   int n_exp   = 0;

   typedef struct {
      logic [XW-1:0] x;
      logic [YW-1:0] y;
   } vec_t;

   vec_t tbl[14];

   isqrt_iter_fsm #(.X_WIDTH(XW)) dut (
      .clk   (clk),
      .rst   (rst),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (y_vld),
      .y     (y),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (y_vld) n_pulse++;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic run_one(input string nm, input logic [XW-1:0] xi,
                          input logic exact, input logic [YW-1:0] ye,
                          output logic [YW-1:0] yo);
      int lat;
      logic [YW-1:0] yh;
      @(negedge clk);
      x     = xi;
      x_vld = 1'b1;
      @(posedge clk);
      #1;
      x_vld = 1'b0;
      chk({nm, "_busy"}, busy, 1);
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (y_vld) begin
            lat = c;
            break;
         end
      end
      yo = y;
      chk({nm, "_lat"}, lat, 16);
      chk({nm, "_idle"}, busy, 0);
      if (exact) chk({nm, "_y"}, yo, ye);
      n_exp++;
      yh = y;
      @(posedge clk);
      #1;
      chk({nm, "_vld_drop"}, y_vld, 0);
      chk({nm, "_y_hold"}, y, yh);
   endtask

   task automatic seq2(input string nm, input logic hold,
                       input logic [XW-1:0] x1, input logic [XW-1:0] x2,
                       input logic [YW-1:0] e1, input logic [YW-1:0] e2);
      int c1 = 0;
      int c2 = 0;
      int np = 0;
      logic [YW-1:0] y1 = '0;
      logic [YW-1:0] y2 = '0;
      @(negedge clk);
      x     = x1;
      x_vld = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) x_vld = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk);
         #1;
         if (hold && c == 5) x = x2;
         if (c1 != 0 && c == c1 + 1) x_vld = 1'b0;
         if (y_vld) begin
            np++;
            if (c1 == 0) begin
               c1 = c;
               y1 = y;
               if (!hold) begin
                  x     = x2;
                  x_vld = 1'b1;
               end
            end else begin
               c2 = c;
               y2 = y;
            end
         end
      end
      x_vld = 1'b0;
      n_exp += 2;
      chk({nm, "_c1"}, c1, 16);
      chk({nm, "_y1"}, y1, e1);
      chk({nm, "_c2"}, c2, 33);
      chk({nm, "_y2"}, y2, e2);
      chk({nm, "_npulse"}, np, 2);
   endtask

   initial begin
      logic [YW-1:0] yo;
      logic [63:0]   x64;
      logic [63:0]   y64;
      logic [63:0]   kk;
      logic          ok;
      int            k;
      int            sel;

      tbl[0]  = '{32'd0,        16'd0};
      tbl[1]  = '{32'd1,        16'd1};
      tbl[2]  = '{32'd15,       16'd3};
      tbl[3]  = '{32'd16,       16'd4};
      tbl[4]  = '{32'hFFFF_FFFF, 16'hFFFF};
      tbl[5]  = '{32'hFFFE_0001, 16'hFFFF};
      tbl[6]  = '{32'hFFFE_0000, 16'hFFFE};
      tbl[7]  = '{32'h4000_0000, 16'h8000};
      tbl[8]  = '{32'd2,        16'd1};
      tbl[9]  = '{32'd3,        16'd1};
      tbl[10] = '{32'd4,        16'd2};
      tbl[11] = '{32'd99,       16'd9};
      tbl[12] = '{32'd100,      16'd10};
      tbl[13] = '{32'd1000,     16'd31};

      #12;
      chk("rst_vld", y_vld, 0);
      chk("rst_y", y, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;

      foreach (tbl[i])
         run_one($sformatf("tbl%0d", i), tbl[i].x, 1'b1, tbl[i].y, yo);

      seq2("hold", 1'b1, 32'd100, 32'd81, 16'd10, 16'd9);
      seq2("b2b", 1'b0, 32'd49, 32'd144, 16'd7, 16'd12);

      @(negedge clk);
      x     = 32'd1000;
      x_vld = 1'b1;
      @(posedge clk);
      #1;
      x_vld = 1'b0;
      repeat (8) @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_vld", y_vld, 0);
      chk("arst_y", y, 0);
      chk("arst_busy", busy, 0);
      @(negedge clk);
      x     = 32'd5;
      x_vld = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_xvld_ign", busy, 0);
      @(negedge clk);
      x_vld = 1'b0;
      rst   = 1'b1;
      run_one("post_rst", 32'd1000, 1'b1, 16'd31, yo);

      for (int i = 0; i < 2000; i++) begin
         k   = $urandom_range(0, 65535);
         sel = $urandom_range(0, 2);
         kk  = 64'(k) * 64'(k);
         if (sel == 0) x64 = kk;
         else if (sel == 1) x64 = (k == 0) ? 64'd0 : kk - 64'd1;
         else x64 = 64'($urandom);
         x64 = {32'd0, x64[31:0]};
         run_one("rand", x64[31:0], 1'b0, '0, yo);
         y64 = {48'd0, yo};
         ok  = (y64 * y64 <= x64) && ((y64 + 1) * (y64 + 1) > x64);
         n_chk++;
         if (!ok) begin
            n_err++;
            $display("FAIL rand_bound: x=%0h got y=%0h", x64, yo);
         end
      end

      @(posedge clk);
      #1;
      chk("pulse_total", n_pulse, n_exp);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
